// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Digit-serial two's-complement subtractor, InputA - InputB,
//                DIGIT bits per clock, Start/Busy/Done handshake. The result
//                and its flags are held until the next operation completes.
//                Optional ZeroFlag output when SUB_ZERO_FLAG_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
   parameter int N     = 16,
   parameter int DIGIT = 4
) (
   input  logic         Clk,
   input  logic         Rst,
   input  logic         Start,
   input  logic [N-1:0] InputA,
   input  logic [N-1:0] InputB,
   output logic         Busy,
   output logic         Done,
   output logic [N-1:0] OutDiff,
   output logic         BorrowOut,
`ifdef SUB_ZERO_FLAG_EN
   output logic         ZeroFlag,
`endif
   output logic         OverFlow
);

   localparam int NUM_DIGITS = N / DIGIT;
   localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

   // Operand width must split into whole digits.
   generate
      if ((N % DIGIT) != 0 || DIGIT < 1) begin : g_param_check
         $error("serial_subtractor: N must be a positive multiple of DIGIT");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t           state_q,  state_d;
   logic [N-1:0]     a_q,      a_d;
   logic [N-1:0]     b_q,      b_d;
   logic             carry_q,  carry_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [N-1:0]     res_q,    res_d;
   logic             sa_q,     sa_d;
   logic             sb_q,     sb_d;
   logic [N-1:0]     diff_q,   diff_d;
   logic             borrow_q, borrow_d;
   logic             ovf_q,    ovf_d;

   logic [DIGIT:0]   digit_sum;
   logic [N-1:0]     res_shift;
   logic             last_step;

   // One digit of A + ~B + carry; the top bit is the carry into the next digit.
   always_comb begin
      digit_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, carry_q};
   end

   // New digit enters the result from the MSB side; older digits move down.
   generate
      if (DIGIT == N) begin : g_res_single
         assign res_shift = digit_sum[DIGIT-1:0];
      end else begin : g_res_multi
         assign res_shift = {digit_sum[DIGIT-1:0], res_q[N-1:DIGIT]};
      end
   endgenerate

   assign last_step = (state_q == S_RUN) && (cnt_q == LAST_DIGIT);

   // Next-state, datapath and result-capture logic.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      res_d    = res_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;
      case (state_q)
         S_IDLE, S_FIN: begin
            if (Start) begin
               // Subtraction as A + ~B + 1: the +1 rides in on the carry.
               state_d = S_RUN;
               a_d     = InputA;
               b_d     = ~InputB;
               carry_d = 1'b1;
               cnt_d   = '0;
               sa_d    = InputA[N-1];
               sb_d    = InputB[N-1];
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            carry_d = digit_sum[DIGIT];
            cnt_d   = cnt_q + CNT_W'(1);
            res_d   = res_shift;
            if (last_step) begin
               state_d  = S_FIN;
               diff_d   = res_shift;
               // No carry out of A + ~B + 1 means A < B.
               borrow_d = ~digit_sum[DIGIT];
               ovf_d    = (sa_q ^ sb_q) & (sa_q ^ res_shift[N-1]);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         res_q    <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         res_q    <= res_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
      end
   end

`ifdef SUB_ZERO_FLAG_EN
   logic zero_q, zero_d;

   // Zero flag captured together with the result.
   always_comb begin
      zero_d = zero_q;
      if (last_step) begin
         zero_d = (res_shift == '0);
      end
   end

   // Zero flag register.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         zero_q <= 1'b0;
      end else begin
         zero_q <= zero_d;
      end
   end

   assign ZeroFlag = zero_q;
`else
   // Zero detection not built in this configuration.
`endif

   assign Busy      = (state_q == S_RUN);
   assign Done      = (state_q == S_FIN);
   assign OutDiff   = diff_q;
   assign BorrowOut = borrow_q;
   assign OverFlow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Self-checking bench for serial_subtractor (N=16, DIGIT=4):
//                directed vector table, handshake and reset sequences, and
//                random operations against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

   localparam int N     = 16;
   localparam int DIGIT = 4;
   localparam int ND    = N / DIGIT;

   logic         Clk = 1'b0;
   logic         Rst;
   logic         Start;
   logic [N-1:0] InputA;
   logic [N-1:0] InputB;
   logic         Busy;
   logic         Done;
   logic [N-1:0] OutDiff;
   logic         BorrowOut;
   logic         OverFlow;
`ifdef SUB_ZERO_FLAG_EN
   logic         ZeroFlag;
`endif

   int checks   = 0;
   int failures = 0;

   // Values the outputs must hold until the next completion.
   logic [N-1:0] h_diff;
   logic         h_br;
   logic         h_ov;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [N-1:0] d;
      logic         br;
      logic         ov;
   } vec_t;

   vec_t vecs [8];

   serial_subtractor #(.N(N), .DIGIT(DIGIT)) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .Start     (Start),
      .InputA    (InputA),
      .InputB    (InputB),
      .Busy      (Busy),
      .Done      (Done),
      .OutDiff   (OutDiff),
      .BorrowOut (BorrowOut),
`ifdef SUB_ZERO_FLAG_EN
      .ZeroFlag  (ZeroFlag),
`endif
      .OverFlow  (OverFlow)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Reference: plain integer subtraction, unsigned compare, signed range test.
   function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 output logic [N-1:0] d, output logic br, output logic ov);
      int sa, sb, sd;
      d  = a - b;
      br = (a < b);
      sa = $signed(a);
      sb = $signed(b);
      sd = sa - sb;
      ov = (sd > 32767) || (sd < -32768);
   endfunction

   // Full operation: accept, N/DIGIT busy cycles, Done with result.
   // Leaves the bench sampling in the FIN cycle.
   task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] ed, input logic eb, input logic eo,
                        input string name);
      InputA = a;
      InputB = b;
      Start  = 1'b1;
      step();
      Start  = 1'b0;
      InputA = N'($urandom);
      InputB = N'($urandom);
      for (int i = 0; i < ND; i++) begin
         check({name, " busy"}, {31'd0, Busy}, 32'd1);
         check({name, " done_early"}, {31'd0, Done}, 32'd0);
         if (i == 0) begin
            check({name, " held_diff"}, {16'd0, OutDiff}, {16'd0, h_diff});
            check({name, " held_flags"}, {30'd0, BorrowOut, OverFlow}, {30'd0, h_br, h_ov});
         end
         if (i != ND - 1) step();
      end
      step();
      check({name, " done"}, {30'd0, Done, Busy}, 32'd2);
      check({name, " diff"}, {16'd0, OutDiff}, {16'd0, ed});
      check({name, " borrow"}, {31'd0, BorrowOut}, {31'd0, eb});
      check({name, " overflow"}, {31'd0, OverFlow}, {31'd0, eo});
`ifdef SUB_ZERO_FLAG_EN
      check({name, " zero"}, {31'd0, ZeroFlag}, {31'd0, (ed == '0)});
`endif
      h_diff = ed;
      h_br   = eb;
      h_ov   = eo;
   endtask

   task automatic idle_check(input string name);
      step();
      check({name, " idle"}, {30'd0, Done, Busy}, 32'd0);
   endtask

   initial begin
      logic [N-1:0] ra, rb, rd;
      logic         rbr, rov;

      vecs[0] = '{a:16'h0005, b:16'h0003, d:16'h0002, br:1'b0, ov:1'b0};
      vecs[1] = '{a:16'h0003, b:16'h0005, d:16'hFFFE, br:1'b1, ov:1'b0};
      vecs[2] = '{a:16'h8000, b:16'h0001, d:16'h7FFF, br:1'b0, ov:1'b1};
      vecs[3] = '{a:16'h7FFF, b:16'hFFFF, d:16'h8000, br:1'b1, ov:1'b1};
      vecs[4] = '{a:16'h1234, b:16'h1234, d:16'h0000, br:1'b0, ov:1'b0};
      vecs[5] = '{a:16'h1235, b:16'h1234, d:16'h0001, br:1'b0, ov:1'b0};
      vecs[6] = '{a:16'h0000, b:16'hFFFF, d:16'h0001, br:1'b1, ov:1'b0};
      vecs[7] = '{a:16'hFFFF, b:16'h0000, d:16'hFFFF, br:1'b0, ov:1'b0};

      Rst    = 1'b1;
      Start  = 1'b0;
      InputA = '0;
      InputB = '0;
      h_diff = '0;
      h_br   = 1'b0;
      h_ov   = 1'b0;
      step();
      step();
      Rst = 1'b0;
      check("reset busy_done", {30'd0, Busy, Done}, 32'd0);
      check("reset diff", {16'd0, OutDiff}, 32'd0);
      check("reset flags", {30'd0, BorrowOut, OverFlow}, 32'd0);
`ifdef SUB_ZERO_FLAG_EN
      check("reset zero", {31'd0, ZeroFlag}, 32'd0);
`endif

      // Directed vectors, each separated by an idle cycle.
      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].br, vecs[i].ov, $sformatf("vec%0d", i));
         idle_check($sformatf("vec%0d", i));
      end

      // Start during Busy is ignored and not queued.
      InputA = 16'h0100;
      InputB = 16'h0001;
      Start  = 1'b1;
      step();
      Start  = 1'b0;
      step();
      InputA = 16'h1111;
      InputB = 16'h0001;
      Start  = 1'b1;
      step();
      Start  = 1'b0;
      check("ignore busy", {31'd0, Busy}, 32'd1);
      step();
      step();
      check("ignore done", {31'd0, Done}, 32'd1);
      check("ignore diff", {16'd0, OutDiff}, 32'h00FF);
      h_diff = 16'h00FF;
      h_br   = 1'b0;
      h_ov   = 1'b0;
      idle_check("ignore no_queue");

      // Back-to-back: second Start lands in FIN, no idle cycle between ops.
      do_op(16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, "b2b first");
      do_op(16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b0, "b2b second");
      idle_check("b2b");

      // Reset in the second RUN cycle aborts with cleared outputs.
      do_op(16'h0009, 16'h0002, 16'h0007, 1'b0, 1'b0, "pre_reset");
      idle_check("pre_reset");
      InputA = 16'h4000;
      InputB = 16'h0001;
      Start  = 1'b1;
      step();
      Start  = 1'b0;
      step();
      Rst = 1'b1;
      step();
      Rst = 1'b0;
      check("abort busy_done", {30'd0, Busy, Done}, 32'd0);
      check("abort diff", {16'd0, OutDiff}, 32'd0);
      check("abort flags", {30'd0, BorrowOut, OverFlow}, 32'd0);
      for (int i = 0; i < ND + 1; i++) begin
         step();
         check("abort no_done", {31'd0, Done}, 32'd0);
      end
      h_diff = '0;
      h_br   = 1'b0;
      h_ov   = 1'b0;

      // Random operations, mixing back-to-back and idle gaps.
      for (int i = 0; i < 40; i++) begin
         ra = N'($urandom);
         rb = N'($urandom);
         if (i % 8 == 0) rb = ra;
         model(ra, rb, rd, rbr, rov);
         do_op(ra, rb, rd, rbr, rov, $sformatf("rand%0d", i));
         if ($urandom_range(1, 0) == 1) idle_check($sformatf("rand%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
